traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Parametrised two-approach traffic-light controller: the next-generation core behind the three-colour light top level. It sequences main (A) and side (B) approaches through green/yellow/all-red phases with configurable durations and a one-second tick divider. It adds pedestrian-request shortening, night-flash, manual-step and all-red modes, and drives a multiplexed two-digit countdown on the seven-segment display.

## Interface
- TICK_DIV, 50_000_000: clock cycles per countdown tick (1 s at 50 MHz); ≥2
- GREEN_S, 25: green duration in ticks; 1..99
- YELLOW_S, 3: yellow duration in ticks; 1..99
- CLEAR_S, 2: all-red clearance in ticks; 1..99
- PED_S, 5: remaining green after a pedestrian request; 1..GREEN_S
- FLASH_DIV, 25_000_000: cycles per yellow-flash half period
- SCAN_DIV, 50_000: cycles per display digit slot
- Sys_CLK  in  1  sole clock; all logic on rising edge
- Sys_RST  in  1  synchronous, active-high reset
- Key  in  2  [0] pedestrian request, [1] manual step; debounced upstream, active-high
- Switch  in  2  mode: 00 normal, 01 night flash, 10 manual, 11 all-red hold
- LIGHT_A  out  3  {R,Y,G} for approach A, active-high
- LIGHT_B  out  3  {R,Y,G} for approach B, active-high
- SEG  out  8  {dp,g,f,e,d,c,b,a}, active-low
- COM  out  2  digit enables, active-low; [0] units, [1] tens

## Operation
- Key and Switch pass through 2-flop synchronisers; Key gets a rising-edge detect (one-cycle pulse).
- Phases: A_G (A green, B red) → A_Y → CLR_A (both red) → B_G → B_Y → CLR_B → A_G.
- On phase entry: cnt ← phase duration, tick divider ← 0. Each tick (divider = TICK_DIV−1): cnt decrements; the tick on which cnt = 1 advances the phase instead. A phase therefore lasts exactly duration×TICK_DIV cycles.
- Pedestrian pulse in A_G or B_G with cnt > PED_S: cnt ← PED_S, divider not reset. Ignored in other phases, in other modes, or when cnt ≤ PED_S.
- Night (01): both approaches show yellow only, toggling every FLASH_DIV cycles, starting on. Display blank.
- Manual (10): cnt and divider frozen. A Key[1] pulse advances one phase and reloads cnt. Display shows "--".
- All-red (11): both red; phase register forced to CLR_B. Display blank.
- Leaving any non-normal mode for normal: enter CLR_B with cnt = CLEAR_S, so all-red clearance always precedes A_G.
- Pedestrian and tick in the same cycle: the pedestrian load wins; the decrement is discarded.
- Simultaneous mode change and tick: the mode change wins.
- Display in normal mode: the tens digit is blanked when cnt < 10. Slots alternate units/tens every SCAN_DIV cycles.

## Timing
- Reset values: phase A_G, cnt = GREEN_S, dividers 0, LIGHT_A = 001, LIGHT_B = 100, SEG = 8'hFF, COM = 2'b11. The first digit is enabled after the first SCAN_DIV slot.
- Reset asserted mid-operation returns every register to its reset value on the next edge.
- Latency: input pin → synchronised pulse 2 cycles; pulse → cnt/phase update +1 cycle; phase → LIGHT outputs registered, +1 cycle.
- COM and SEG change on the same edge, so there is no ghosting cycle.
- cnt is 7 bits unsigned. Binary-to-two-digit BCD is combinational (cnt ≤ 99).
- Elaboration-time check that all durations are 1..99 and PED_S ≤ GREEN_S.

## Structure
- Package tlc_pkg: phase enum, mode encodings, {R,Y,G} light constants, 7-seg patterns for 0–9, dash, blank.
- Sub-module seg_scan: takes two BCD digits plus blank/dash flags and owns the scan divider, COM and SEG registers.
- Top contains the synchronisers, tick and flash dividers, phase FSM and countdown.

## Test plan
Common parameters: TICK_DIV=4, GREEN_S=5, YELLOW_S=2, CLEAR_S=1, PED_S=2, FLASH_DIV=3, SCAN_DIV=2.
- Normal cycle after reset: A green 20 cycles, A yellow 8, all-red 4, B green 20, B yellow 8, all-red 4. Full period 64 cycles, repeating.
- Key[0] pulse while A_G cnt=5: cnt reads 2 three cycles later; A_Y entered after the remaining ticks. A pulse during A_Y leaves timing unchanged.
- Switch=01: both yellow toggling every 3 cycles, reds off, SEG=FF. Switch→00: CLR_B for 4 cycles, then A_G cnt=5.
- Switch=10 for 200 cycles: no phase change. Each Key[1] pulse advances exactly one phase; SEG shows the dash pattern on both digits.
- Sys_RST pulsed during B_Y: next cycle phase A_G, cnt=5, LIGHT_A=001, LIGHT_B=100, COM=11.
- Scan: COM alternates 10/01 every 2 cycles. With cnt=5, units slot SEG = "5" pattern and tens slot SEG = FF.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic-light controller: phases, modes,
// {R,Y,G} light codes and active-low seven-segment patterns.
package tlc_pkg;

    typedef enum logic [2:0] {
        PH_A_G,
        PH_A_Y,
        PH_CLR_A,
        PH_B_G,
        PH_B_Y,
        PH_CLR_B
    } phase_e;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_NIGHT  = 2'b01,
        MODE_MANUAL = 2'b10,
        MODE_ALLRED = 2'b11
    } mode_e;

    localparam logic [2:0] LT_OFF = 3'b000;
    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low, decimal point always off
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 8'hC0;
            4'd1:    seg_digit = 8'hF9;
            4'd2:    seg_digit = 8'hA4;
            4'd3:    seg_digit = 8'hB0;
            4'd4:    seg_digit = 8'h99;
            4'd5:    seg_digit = 8'h92;
            4'd6:    seg_digit = 8'h82;
            4'd7:    seg_digit = 8'hF8;
            4'd8:    seg_digit = 8'h80;
            4'd9:    seg_digit = 8'h90;
            default: seg_digit = SEG_BLANK;
        endcase
    endfunction

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            PH_A_G:   next_phase = PH_A_Y;
            PH_A_Y:   next_phase = PH_CLR_A;
            PH_CLR_A: next_phase = PH_B_G;
            PH_B_G:   next_phase = PH_B_Y;
            PH_B_Y:   next_phase = PH_CLR_B;
            default:  next_phase = PH_A_G;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Two-digit multiplexed seven-segment driver: owns the scan divider and the
// registered COM/SEG outputs so both change on the same edge.
module seg_scan
    import tlc_pkg::*;
#(
    parameter int SCAN_DIV = 50_000
) (
    input  logic       clk_i,
    input  logic       srst_i,
    input  logic [3:0] units_i,
    input  logic [3:0] tens_i,
    input  logic       blank_all_i,
    input  logic       blank_tens_i,
    input  logic       dash_i,
    output logic [7:0] seg_o,
    output logic [1:0] com_o
);
    localparam int SW = $clog2(SCAN_DIV + 1);

    logic [SW-1:0] scan_q, scan_d;
    logic          on_q, on_d;
    logic          slot_q, slot_d;
    logic [7:0]    seg_q, seg_d;
    logic [1:0]    com_q, com_d;
    logic          wrap;

    assign wrap = (scan_q == SW'(SCAN_DIV - 1));

    // Display stays dark until the first slot has elapsed, then starts on units
    always_comb begin
        scan_d = wrap ? '0 : scan_q + SW'(1);
        on_d   = on_q | wrap;
        slot_d = slot_q;
        if (wrap) begin
            slot_d = on_q ? ~slot_q : 1'b0;
        end
        com_d = on_d ? (slot_d ? 2'b01 : 2'b10) : 2'b11;
        seg_d = SEG_BLANK;
        if (on_d && !blank_all_i) begin
            if (dash_i) begin
                seg_d = SEG_DASH;
            end else if (slot_d) begin
                seg_d = blank_tens_i ? SEG_BLANK : seg_digit(tens_i);
            end else begin
                seg_d = seg_digit(units_i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            scan_q <= '0;
            on_q   <= 1'b0;
            slot_q <= 1'b0;
            seg_q  <= SEG_BLANK;
            com_q  <= 2'b11;
        end else begin
            scan_q <= scan_d;
            on_q   <= on_d;
            slot_q <= slot_d;
            seg_q  <= seg_d;
            com_q  <= com_d;
        end
    end

    assign seg_o = seg_q;
    assign com_o = com_q;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-approach traffic-light controller: input synchronisers, tick and flash
// dividers, phase FSM with countdown, special modes and the countdown display.
module traffic_light_ctrl
    import tlc_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int GREEN_S   = 25,
    parameter int YELLOW_S  = 3,
    parameter int CLEAR_S   = 2,
    parameter int PED_S     = 5,
    parameter int FLASH_DIV = 25_000_000,
    parameter int SCAN_DIV  = 50_000
) (
    input  logic       Sys_CLK,
    input  logic       Sys_RST,
    input  logic [1:0] Key,
    input  logic [1:0] Switch,
    output logic [2:0] LIGHT_A,
    output logic [2:0] LIGHT_B,
    output logic [7:0] SEG,
    output logic [1:0] COM
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int FW = $clog2(FLASH_DIV + 1);

    if (TICK_DIV < 2 || FLASH_DIV < 1 || SCAN_DIV < 1
        || GREEN_S < 1 || GREEN_S > 99 || YELLOW_S < 1 || YELLOW_S > 99
        || CLEAR_S < 1 || CLEAR_S > 99 || PED_S < 1 || PED_S > GREEN_S) begin : g_param_check
        $error("traffic_light_ctrl: illegal timing parameters");
    end

    function automatic logic [6:0] dur(input phase_e p);
        case (p)
            PH_A_G, PH_B_G: dur = 7'(GREEN_S);
            PH_A_Y, PH_B_Y: dur = 7'(YELLOW_S);
            default:        dur = 7'(CLEAR_S);
        endcase
    endfunction

    logic [1:0] key_s1_q, key_s2_q, key_s3_q;
    logic [1:0] sw_s1_q, sw_s2_q;
    mode_e      mode, mode_prev_q;
    logic       ped_pulse, step_pulse, leaving, tick;

    phase_e        phase_q, phase_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [TW-1:0] div_q, div_d;
    logic [FW-1:0] fdiv_q, fdiv_d;
    logic          flash_q, flash_d;
    logic [2:0]    la_q, la_d, lb_q, lb_d;

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            key_s1_q    <= '0;
            key_s2_q    <= '0;
            key_s3_q    <= '0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            mode_prev_q <= MODE_NORMAL;
        end else begin
            key_s1_q    <= Key;
            key_s2_q    <= key_s1_q;
            key_s3_q    <= key_s2_q;
            sw_s1_q     <= Switch;
            sw_s2_q     <= sw_s1_q;
            mode_prev_q <= mode;
        end
    end

    assign mode       = mode_e'(sw_s2_q);
    assign ped_pulse  = key_s2_q[0] & ~key_s3_q[0];
    assign step_pulse = key_s2_q[1] & ~key_s3_q[1];
    assign leaving    = (mode == MODE_NORMAL) && (mode_prev_q != MODE_NORMAL);
    assign tick       = (div_q == TW'(TICK_DIV - 1));

    // Phase sequencing and countdown; a returning mode change outranks any tick
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        case (mode)
            MODE_NORMAL: begin
                if (leaving) begin
                    phase_d = PH_CLR_B;
                    cnt_d   = 7'(CLEAR_S);
                    div_d   = '0;
                end else begin
                    div_d = tick ? '0 : div_q + TW'(1);
                    if (ped_pulse && (phase_q == PH_A_G || phase_q == PH_B_G)
                        && cnt_q > 7'(PED_S)) begin
                        cnt_d = 7'(PED_S);
                    end else if (tick) begin
                        if (cnt_q == 7'd1) begin
                            phase_d = next_phase(phase_q);
                            cnt_d   = dur(phase_d);
                        end else begin
                            cnt_d = cnt_q - 7'd1;
                        end
                    end
                end
            end
            MODE_MANUAL: begin
                if (step_pulse) begin
                    phase_d = next_phase(phase_q);
                    cnt_d   = dur(phase_d);
                end
            end
            MODE_ALLRED: phase_d = PH_CLR_B;
            default: ;
        endcase
    end

    always_comb begin
        fdiv_d  = fdiv_q;
        flash_d = flash_q;
        if (mode != MODE_NIGHT) begin
            fdiv_d  = '0;
            flash_d = 1'b1;
        end else if (fdiv_q == FW'(FLASH_DIV - 1)) begin
            fdiv_d  = '0;
            flash_d = ~flash_q;
        end else begin
            fdiv_d = fdiv_q + FW'(1);
        end
    end

    // The cycle that returns to normal shows all-red before the phase reloads
    always_comb begin
        la_d = LT_RED;
        lb_d = LT_RED;
        case (mode)
            MODE_NIGHT: begin
                la_d = flash_q ? LT_YEL : LT_OFF;
                lb_d = flash_q ? LT_YEL : LT_OFF;
            end
            MODE_ALLRED: ;
            default: begin
                if (!leaving) begin
                    case (phase_q)
                        PH_A_G:  la_d = LT_GRN;
                        PH_A_Y:  la_d = LT_YEL;
                        PH_B_G:  lb_d = LT_GRN;
                        PH_B_Y:  lb_d = LT_YEL;
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge Sys_CLK) begin
        if (Sys_RST) begin
            phase_q <= PH_A_G;
            cnt_q   <= 7'(GREEN_S);
            div_q   <= '0;
            fdiv_q  <= '0;
            flash_q <= 1'b1;
            la_q    <= LT_GRN;
            lb_q    <= LT_RED;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            fdiv_q  <= fdiv_d;
            flash_q <= flash_d;
            la_q    <= la_d;
            lb_q    <= lb_d;
        end
    end

    assign LIGHT_A = la_q;
    assign LIGHT_B = lb_q;

    logic [3:0] units, tens;
    logic       blank_all, blank_tens, dash;

    assign tens       = 4'(cnt_q / 7'd10);
    assign units      = 4'(cnt_q % 7'd10);
    assign blank_tens = (cnt_q < 7'd10);
    assign blank_all  = (mode == MODE_NIGHT) || (mode == MODE_ALLRED);
    assign dash       = (mode == MODE_MANUAL);

    seg_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_seg_scan (
        .clk_i       (Sys_CLK),
        .srst_i      (Sys_RST),
        .units_i     (units),
        .tens_i      (tens),
        .blank_all_i (blank_all),
        .blank_tens_i(blank_tens),
        .dash_i      (dash),
        .seg_o       (SEG),
        .com_o       (COM)
    );

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: stimulus queues timed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_traffic_light_ctrl;
    localparam int F_LA  = 0;
    localparam int F_LB  = 1;
    localparam int F_SEG = 2;
    localparam int F_COM = 3;

    typedef struct {
        int         cyc;
        int         fld;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key = 2'b00;
    logic [1:0] sw  = 2'b00;
    logic [2:0] la, lb;
    logic [7:0] seg;
    logic [1:0] com;
    logic [7:0] act;

    int cyc   = 0;
    int base  = 0;
    int total = 0;
    int bad   = 0;

    traffic_light_ctrl #(
        .TICK_DIV (4),
        .GREEN_S  (5),
        .YELLOW_S (2),
        .CLEAR_S  (1),
        .PED_S    (2),
        .FLASH_DIV(3),
        .SCAN_DIV (2)
    ) dut (
        .Sys_CLK(clk),
        .Sys_RST(rst),
        .Key    (key),
        .Switch (sw),
        .LIGHT_A(la),
        .LIGHT_B(lb),
        .SEG    (seg),
        .COM    (com)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_at(input int k, input int fld, input logic [7:0] v, input string tag);
        exp_t e;
        e.cyc = base + k;
        e.fld = fld;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        key = 2'b00;
        sw  = 2'b00;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        base = cyc;
    endtask

    // Monitor: compares every queued expectation on its cycle
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    case (sb[i].fld)
                        F_LA:    act = {5'b0, la};
                        F_LB:    act = {5'b0, lb};
                        F_SEG:   act = seg;
                        default: act = {6'b0, com};
                    endcase
                    total++;
                    if (sb[i].cyc < cyc) begin
                        bad++;
                        $display("FAIL %s: check at cycle %0d was skipped (now %0d)",
                                 sb[i].tag, sb[i].cyc, cyc);
                    end else if (act !== sb[i].val) begin
                        bad++;
                        $display("FAIL %s: cycle %0d got %h expected %h",
                                 sb[i].tag, cyc, act, sb[i].val);
                    end else begin
                        $display("ok   %s: cycle %0d value %h", sb[i].tag, cyc, act);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Normal cycle from reset, including display scan
        do_reset();
        exp_at(1,  F_LA,  8'h01, "rst_la");
        exp_at(1,  F_LB,  8'h04, "rst_lb");
        exp_at(1,  F_SEG, 8'hFF, "rst_seg");
        exp_at(1,  F_COM, 8'h03, "rst_com");
        exp_at(2,  F_COM, 8'h02, "scan_units_com");
        exp_at(2,  F_SEG, 8'h92, "scan_units_5");
        exp_at(4,  F_COM, 8'h01, "scan_tens_com");
        exp_at(4,  F_SEG, 8'hFF, "scan_tens_blank");
        exp_at(6,  F_COM, 8'h02, "scan_units_com2");
        exp_at(6,  F_SEG, 8'h99, "scan_units_4");
        exp_at(20, F_LA,  8'h01, "ag_last");
        exp_at(21, F_LA,  8'h02, "ay_first");
        exp_at(28, F_LA,  8'h02, "ay_last");
        exp_at(29, F_LA,  8'h04, "clra_first");
        exp_at(32, F_LB,  8'h04, "clra_last_b");
        exp_at(33, F_LB,  8'h01, "bg_first");
        exp_at(33, F_LA,  8'h04, "bg_a_red");
        exp_at(52, F_LB,  8'h01, "bg_last");
        exp_at(53, F_LB,  8'h02, "by_first");
        exp_at(60, F_LB,  8'h02, "by_last");
        exp_at(61, F_LB,  8'h04, "clrb_first");
        exp_at(64, F_LA,  8'h04, "clrb_last_a");
        exp_at(64, F_LB,  8'h04, "clrb_last_b");
        exp_at(65, F_LA,  8'h01, "ag2_first");
        exp_at(65, F_LB,  8'h04, "ag2_b_red");
        exp_at(85, F_LA,  8'h02, "ay2_first");
        wait_to(87);

        // Pedestrian shortening (coincides with a tick) and ignored press in A_Y
        do_reset();
        exp_at(6,  F_SEG, 8'hA4, "ped_cnt2");
        exp_at(7,  F_SEG, 8'hA4, "ped_cnt2_hold");
        exp_at(12, F_LA,  8'h01, "ped_ag_last");
        exp_at(13, F_LA,  8'h02, "ped_ay_first");
        exp_at(20, F_LA,  8'h02, "ped_ay_last");
        exp_at(21, F_LA,  8'h04, "ped_in_ay_ignored");
        exp_at(24, F_LB,  8'h04, "ped_clra_b");
        exp_at(25, F_LB,  8'h01, "ped_bg_first");
        wait_to(1);  key = 2'b01;
        wait_to(3);  key = 2'b00;
        wait_to(13); key = 2'b01;
        wait_to(15); key = 2'b00;
        wait_to(26);

        // Night flash and return through all-red clearance
        do_reset();
        exp_at(4,  F_LA,  8'h02, "night_a_on");
        exp_at(4,  F_LB,  8'h02, "night_b_on");
        exp_at(6,  F_LA,  8'h02, "night_on_end");
        exp_at(6,  F_SEG, 8'hFF, "night_seg_u");
        exp_at(7,  F_LA,  8'h00, "night_a_off");
        exp_at(7,  F_LB,  8'h00, "night_b_off");
        exp_at(9,  F_LA,  8'h00, "night_off_end");
        exp_at(10, F_LA,  8'h02, "night_on_again");
        exp_at(10, F_SEG, 8'hFF, "night_seg_u2");
        exp_at(14, F_LA,  8'h00, "night_last");
        exp_at(15, F_LA,  8'h04, "exit_a_red");
        exp_at(15, F_LB,  8'h04, "exit_b_red");
        exp_at(18, F_SEG, 8'hF9, "exit_clrb_cnt1");
        exp_at(19, F_LA,  8'h04, "exit_clrb_last");
        exp_at(20, F_LA,  8'h01, "exit_ag_a");
        exp_at(20, F_LB,  8'h04, "exit_ag_b");
        exp_at(22, F_SEG, 8'h92, "exit_ag_cnt5");
        exp_at(22, F_COM, 8'h02, "exit_ag_com");
        wait_to(1);  sw = 2'b01;
        wait_to(12); sw = 2'b00;
        wait_to(23);

        // Manual stepping with dash display, then return to normal
        do_reset();
        exp_at(10,  F_SEG, 8'hBF, "man_dash_u");
        exp_at(12,  F_SEG, 8'hBF, "man_dash_t");
        exp_at(12,  F_COM, 8'h01, "man_com_t");
        exp_at(100, F_LA,  8'h01, "man_frozen");
        exp_at(203, F_LA,  8'h01, "man_pre_step");
        exp_at(204, F_LA,  8'h02, "man_step_ay");
        exp_at(204, F_LB,  8'h04, "man_step_ay_b");
        exp_at(213, F_LA,  8'h02, "man_pre_step2");
        exp_at(214, F_LA,  8'h04, "man_step_clra");
        exp_at(214, F_LB,  8'h04, "man_step_clra_b");
        exp_at(223, F_LB,  8'h04, "man_pre_step3");
        exp_at(224, F_LB,  8'h01, "man_step_bg");
        exp_at(224, F_LA,  8'h04, "man_step_bg_a");
        exp_at(240, F_LB,  8'h01, "man_bg_frozen");
        exp_at(242, F_LB,  8'h01, "man_exit_pre");
        exp_at(243, F_LA,  8'h04, "man_exit_a_red");
        exp_at(243, F_LB,  8'h04, "man_exit_b_red");
        exp_at(247, F_LA,  8'h04, "man_exit_clrb");
        exp_at(248, F_LA,  8'h01, "man_exit_ag");
        exp_at(248, F_LB,  8'h04, "man_exit_ag_b");
        wait_to(1);   sw  = 2'b10;
        wait_to(200); key = 2'b10;
        wait_to(202); key = 2'b00;
        wait_to(210); key = 2'b10;
        wait_to(212); key = 2'b00;
        wait_to(220); key = 2'b10;
        wait_to(222); key = 2'b00;
        wait_to(240); sw  = 2'b00;
        wait_to(249);

        // Reset during B_Y, then all-red hold
        do_reset();
        exp_at(55, F_LB,  8'h02, "pre_rst_by");
        exp_at(55, F_LA,  8'h04, "pre_rst_a");
        exp_at(56, F_LA,  8'h01, "mid_rst_la");
        exp_at(56, F_LB,  8'h04, "mid_rst_lb");
        exp_at(56, F_COM, 8'h03, "mid_rst_com");
        exp_at(56, F_SEG, 8'hFF, "mid_rst_seg");
        exp_at(57, F_COM, 8'h03, "mid_rst_com2");
        exp_at(58, F_COM, 8'h02, "mid_rst_units");
        exp_at(58, F_SEG, 8'h92, "mid_rst_cnt5");
        exp_at(68, F_LA,  8'h01, "allred_pre");
        exp_at(69, F_LA,  8'h04, "allred_a");
        exp_at(69, F_LB,  8'h04, "allred_b");
        exp_at(70, F_SEG, 8'hFF, "allred_seg_u");
        exp_at(72, F_SEG, 8'hFF, "allred_seg_t");
        wait_to(55); rst = 1'b1;
        wait_to(56); rst = 1'b0;
        wait_to(66); sw  = 2'b11;
        wait_to(73);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
            total += sb.size();
            bad   += sb.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
